mux_scan_ctrl: RTL and testbench

//   Upstream sequencer for the 4:1 mux stage. Drives the mux select, steps it through all

---
 rtl/mux_scan_ctrl.sv | 85 ++++++++
 tb/tb_mux_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 mux stage: steps the select through every channel, waits a
// settle time on each, samples the mux output and publishes the scanned word.
module mux_scan_ctrl #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned SW     = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           continuous,
    output logic [SW-1:0]  s,
    input  logic           y,
    output logic [NCH-1:0] data,
    output logic           valid,
    output logic           busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    // The last channel goes straight into data, so only NCH-1 bits need holding.
    logic [NCH-2:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            s      <= '0;
            cnt    <= '0;
            shadow <= '0;
            data   <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    s    <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SETTLE - 1))
                        state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    cnt <= '0;
                    if (s == SW'(NCH - 1)) begin
                        data  <= {y, shadow};
                        valid <= 1'b1;
                        s     <= '0;
                        if (continuous) begin
                            state <= ST_SETTLE;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        shadow[s] <= y;
                        s         <= s + 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    s     <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a behavioural 4:1 mux feeds y, expected words
// and their arrival cycle are queued at start and checked when valid pulses.
module tb_mux_scan_ctrl;

    typedef struct {
        logic [3:0] d;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, continuous, y;
    logic [1:0] s;
    logic [3:0] data, i_val;
    logic       valid, busy;

    logic       start1, continuous1, y1;
    logic [1:0] s1;
    logic [3:0] data1, i_val1;
    logic       valid1, busy1;

    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   c;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y  = i_val[s];
    assign y1 = i_val1[s1];

    mux_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .s(s), .y(y), .data(data), .valid(valid), .busy(busy)
    );

    mux_scan_ctrl #(.NCH(4), .SW(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(continuous1),
        .s(s1), .y(y1), .data(data1), .valid(valid1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("data", 32'(data), 32'(e0.d));
                check("valid_cycle", cyc, e0.c);
            end
        end
        if (rst_n === 1'b1 && valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_valid1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("data1", 32'(data1), 32'(e1.d));
                check("valid_cycle1", cyc, e1.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; continuous = 1'b0; i_val = 4'b0000;
        start1 = 1'b0; continuous1 = 1'b0; i_val1 = 4'b0000;

        // Reset state, then idle with no start
        repeat (3) @(negedge clk);
        check("rst_s", 32'(s), 0);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_busy1", 32'(busy1), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_s", 32'(s), 0);

        // Single scan with select stepping and timing
        i_val = 4'b1010;
        c = cyc;
        q0.push_back('{4'b1010, c + 13});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 12; t++) begin
            check("scan_s", 32'(s), 32'(t / 3));
            check("scan_busy", 32'(busy), 1);
            @(negedge clk);
        end
        check("done_busy", 32'(busy), 0);
        check("done_s", 32'(s), 0);
        repeat (4) @(negedge clk);
        check("data_hold", 32'(data), 32'(4'b1010));

        // start re-pulsed mid-scan is ignored
        i_val = 4'b0011;
        c = cyc;
        q0.push_back('{4'b0011, c + 13});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_busy", 32'(busy), 0);
        check("ignored_queue", q0.size(), 0);

        // Continuous: two back-to-back scans, pattern changed between them
        i_val = 4'b0110;
        continuous = 1'b1;
        c = cyc;
        q0.push_back('{4'b0110, c + 13});
        q0.push_back('{4'b1001, c + 25});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            check("cont_busy", 32'(busy), 1);
            if (t == 13) i_val = 4'b1001;
            if (t == 14) continuous = 1'b0;
            @(negedge clk);
        end
        check("cont_end_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        check("cont_idle", 32'(busy), 0);

        // Reset mid-scan aborts with no valid
        i_val = 4'b1100;
        c = cyc;
        q0.push_back('{4'b1100, c + 13});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        #1;
        check("abort_s", 32'(s), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_data", 32'(data), 0);
        check("abort_valid", 32'(valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", 32'(busy), 0);
        i_val = 4'b0111;
        c = cyc;
        q0.push_back('{4'b0111, c + 13});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);

        // SETTLE=1 instance: shorter scan
        i_val1 = 4'b1111;
        c = cyc;
        q1.push_back('{4'b1111, c + 9});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (12) @(negedge clk);
        i_val1 = 4'b0101;
        c = cyc;
        q1.push_back('{4'b0101, c + 9});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;

        for (int w = 0; w < 40 && (q0.size() != 0 || q1.size() != 0); w++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("final_busy1", 32'(busy1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
